uart_tx_buffered: RTL and testbench

//  Parametrised RS-232 transmitter with an internal transmit FIFO.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_fifo.sv | 78 +++++++
 rtl/uart_tx_buffered.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_pkg
// Description : Shared UART constants, transmitter state encoding and the
//               fractional baud increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } txState_t;

    // Rounded increment so the accumulator carry fires at the line rate.
    function automatic longint baud_inc(input longint clkFreq,
                                        input longint baud,
                                        input int     accWidth);
        return ((baud << (accWidth - 4)) + (clkFreq >> 5)) / (clkFreq >> 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous transmit FIFO with occupancy, full/empty flags
//               and a one-cycle pulse for writes dropped while full.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int              c_AW         = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL_LEVEL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wrPtr;
    logic [c_AW-1:0]  r_rdPtr;
    logic [c_AW:0]    r_level;
    logic             r_overflow;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_level == c_FULL_LEVEL);
    assign w_empty = (r_level == '0);
    // A write against a full FIFO is dropped even if a pop frees a slot this cycle.
    assign w_push  = wr_en && !w_full;
    assign w_pop   = rd_en && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr_en && w_full;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign rd_data  = r_mem[r_rdPtr];
    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = r_level;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_buffered
// Description : RS-232 transmitter fed from an internal FIFO, with
//               configurable width, parity and stop bits, and a fractional
//               accumulator baud generator.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int ACC_WIDTH  = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          txd
);

    localparam logic [ACC_WIDTH-1:0] c_INC =
        ACC_WIDTH'(baud_inc(longint'(CLK_FREQ), longint'(BAUD), ACC_WIDTH));
    localparam logic [3:0] c_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] c_LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       c_ODD       = (PARITY == PARITY_ODD);

    txState_t               r_state;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shiftNext;
    logic                   r_parityBit;
    logic [3:0]             r_bitCnt;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [ACC_WIDTH:0]     w_sum;
    logic                   w_tick;
    logic                   r_txd;
    logic                   w_pop;
    logic                   w_lastStop;
    logic [DATA_BITS-1:0]   w_head;
    logic                   w_empty;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (w_pop),
        .rd_data  (w_head),
        .full     (full),
        .empty    (w_empty),
        .level    (level),
        .overflow (overflow)
    );

    // The tick is the carry out of the sum, so it acts on the same edge the
    // accumulator wraps; every bit therefore spans exactly one tick interval.
    assign w_sum       = {1'b0, r_acc} + {1'b0, c_INC};
    assign w_tick      = w_sum[ACC_WIDTH];
    assign w_shiftNext = r_shift >> 1;
    assign w_lastStop  = (r_state == ST_STOP) && w_tick && (r_bitCnt == c_LAST_STOP);
    assign w_pop       = !w_empty && ((r_state == ST_IDLE) || w_lastStop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_parityBit <= 1'b0;
            r_bitCnt    <= '0;
            r_acc       <= '0;
            r_txd       <= 1'b1;
        end else begin
            if (r_state == ST_IDLE) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_sum[ACC_WIDTH-1:0];
            end

            case (r_state)
                ST_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_shift     <= w_head;
                        r_parityBit <= (^w_head) ^ c_ODD;
                        r_bitCnt    <= '0;
                        r_state     <= ST_START;
                        r_txd       <= 1'b0;
                    end
                end

                ST_START: begin
                    if (w_tick) begin
                        r_state  <= ST_DATA;
                        r_bitCnt <= '0;
                        r_txd    <= r_shift[0];
                    end
                end

                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bitCnt == c_LAST_DATA) begin
                            r_bitCnt <= '0;
                            if (PARITY != PARITY_NONE) begin
                                r_state <= ST_PARITY;
                                r_txd   <= r_parityBit;
                            end else begin
                                r_state <= ST_STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_bitCnt <= r_bitCnt + 1'b1;
                            r_shift  <= w_shiftNext;
                            r_txd    <= w_shiftNext[0];
                        end
                    end
                end

                ST_PARITY: begin
                    if (w_tick) begin
                        r_state  <= ST_STOP;
                        r_bitCnt <= '0;
                        r_txd    <= 1'b1;
                    end
                end

                ST_STOP: begin
                    if (w_tick) begin
                        if (r_bitCnt == c_LAST_STOP) begin
                            r_bitCnt <= '0;
                            if (w_pop) begin
                                // Back-to-back frame: restart the bit clock phase.
                                r_shift     <= w_head;
                                r_parityBit <= (^w_head) ^ c_ODD;
                                r_state     <= ST_START;
                                r_acc       <= '0;
                                r_txd       <= 1'b0;
                            end else begin
                                r_state <= ST_IDLE;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_bitCnt <= r_bitCnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign empty = w_empty;
    assign busy  = (r_state != ST_IDLE) || !w_empty;
    assign txd   = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_buffered
// Description : Directed self-checking bench for uart_tx_buffered (16 clk/bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] wrEn;
    logic [7:0] wrData;
    logic [3:0] txd, busy, full, empty, overflow;
    logic [4:0] levelA, levelB, levelC, levelD;

    int nAsserts = 0;
    int nFails   = 0;

    always #5 clk = ~clk;

    // A: 8N1, B: 8E1, C: 8O1, D: 7N2
    uart_tx_buffered #(.CLK_FREQ(1843200), .BAUD(115200)) uA (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn[0]), .wr_data(wrData),
        .full(full[0]), .empty(empty[0]), .level(levelA), .overflow(overflow[0]),
        .busy(busy[0]), .txd(txd[0]));
    uart_tx_buffered #(.CLK_FREQ(1843200), .BAUD(115200), .PARITY(2)) uB (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn[1]), .wr_data(wrData),
        .full(full[1]), .empty(empty[1]), .level(levelB), .overflow(overflow[1]),
        .busy(busy[1]), .txd(txd[1]));
    uart_tx_buffered #(.CLK_FREQ(1843200), .BAUD(115200), .PARITY(1)) uC (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn[2]), .wr_data(wrData),
        .full(full[2]), .empty(empty[2]), .level(levelC), .overflow(overflow[2]),
        .busy(busy[2]), .txd(txd[2]));
    uart_tx_buffered #(.CLK_FREQ(1843200), .BAUD(115200), .DATA_BITS(7), .STOP_BITS(2)) uD (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn[3]), .wr_data(wrData[6:0]),
        .full(full[3]), .empty(empty[3]), .level(levelD), .overflow(overflow[3]),
        .busy(busy[3]), .txd(txd[3]));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mkFrame(input logic [8:0] data, input int nData,
                                            input bit hasPar, input bit parBit);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < nData; i++) f[1 + i] = data[i];
        if (hasPar) f[1 + nData] = parBit;
        return f;
    endfunction

    // Entry: at the negedge of the first start-bit cycle. Exit: one cycle past the frame.
    task automatic checkFrame(input int inst, input logic [15:0] bits, input int nBits,
                              input string tag);
        for (int b = 0; b < nBits; b++) begin
            chk($sformatf("%s bit%0d head", tag, b), 16'(txd[inst]), 16'(bits[b]));
            repeat (15) @(negedge clk);
            chk($sformatf("%s bit%0d tail", tag, b), 16'(txd[inst]), 16'(bits[b]));
            @(negedge clk);
        end
    endtask

    // Single write; returns at the negedge after the write edge.
    task automatic write1(input int inst, input logic [7:0] data);
        wrData     = data;
        wrEn[inst] = 1'b1;
        @(negedge clk);
        wrEn[inst] = 1'b0;
    endtask

    function automatic logic [7:0] word(input int k);
        return 8'(k * 29 + 3);
    endfunction

    initial begin
        rst_n  = 1'b0;
        wrEn   = '0;
        wrData = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst txd",      16'(txd[0]),      16'h1);
        chk("rst busy",     16'(busy[0]),     16'h0);
        chk("rst empty",    16'(empty[0]),    16'h1);
        chk("rst full",     16'(full[0]),     16'h0);
        chk("rst level",    16'(levelA),      16'h0);
        chk("rst overflow", 16'(overflow[0]), 16'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 0x55
        write1(0, 8'h55);
        chk("8n1 latency txd", 16'(txd[0]), 16'h1);
        chk("8n1 busy",        16'(busy[0]), 16'h1);
        @(negedge clk);
        checkFrame(0, mkFrame(9'h055, 8, 1'b0, 1'b0), 9, "8n1");
        chk("8n1 stop head", 16'(txd[0]), 16'h1);
        repeat (15) @(negedge clk);
        chk("8n1 stop tail", 16'(txd[0]), 16'h1);
        chk("8n1 busy@159",  16'(busy[0]), 16'h1);
        @(negedge clk);
        chk("8n1 busy@160",  16'(busy[0]), 16'h0);
        repeat (3) @(negedge clk);

        // Even then odd parity, 0x07
        write1(1, 8'h07);
        @(negedge clk);
        checkFrame(1, mkFrame(9'h007, 8, 1'b1, 1'b1), 11, "8e1");
        chk("8e1 idle", 16'(busy[1]), 16'h0);
        write1(2, 8'h07);
        @(negedge clk);
        checkFrame(2, mkFrame(9'h007, 8, 1'b1, 1'b0), 11, "8o1");
        chk("8o1 idle", 16'(busy[2]), 16'h0);

        // 7N2 0x41
        write1(3, 8'h41);
        @(negedge clk);
        checkFrame(3, mkFrame(9'h041, 7, 1'b0, 1'b0), 10, "7n2");
        chk("7n2 idle", 16'(busy[3]), 16'h0);
        repeat (2) @(negedge clk);

        // Burst of 18 writes into A; frame 1 starts after the 2nd write edge
        wrEn[0] = 1'b1;
        for (int i = 0; i < 18; i++) begin
            wrData = word(i);
            @(negedge clk);
            if (i == 0)  chk("burst level1", 16'(levelA), 16'd1);
            if (i == 16) begin
                chk("burst level16", 16'(levelA), 16'd16);
                chk("burst full",    16'(full[0]), 16'h1);
                chk("burst noovf",   16'(overflow[0]), 16'h0);
            end
            if (i == 17) begin
                chk("burst ovf pulse", 16'(overflow[0]), 16'h1);
                chk("burst level kept", 16'(levelA), 16'd16);
            end
        end
        wrEn[0] = 1'b0;
        @(negedge clk);
        chk("burst ovf end", 16'(overflow[0]), 16'h0);
        repeat (143) @(negedge clk);
        for (int k = 1; k < 17; k++) begin
            checkFrame(0, mkFrame({1'b0, word(k)}, 8, 1'b0, 1'b0), 10,
                       $sformatf("burst f%0d", k + 1));
        end
        chk("burst done busy",  16'(busy[0]),  16'h0);
        chk("burst done empty", 16'(empty[0]), 16'h1);
        chk("burst done txd",   16'(txd[0]),   16'h1);

        // Reset mid-DATA of frame 2 of 3
        wrEn[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wrData = 8'(8'h11 * (i + 1));
            @(negedge clk);
        end
        wrEn[0] = 1'b0;
        repeat (207) @(negedge clk);
        chk("midrst pre level", 16'(levelA), 16'd1);
        chk("midrst pre txd",   16'(txd[0]), 16'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst txd",   16'(txd[0]),   16'h1);
        chk("midrst empty", 16'(empty[0]), 16'h1);
        chk("midrst busy",  16'(busy[0]),  16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        write1(0, 8'hA3);
        @(negedge clk);
        checkFrame(0, mkFrame(9'h0A3, 8, 1'b0, 1'b0), 10, "postrst");
        chk("postrst idle", 16'(busy[0]), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
`default_nettype wire
